tn_wb_gpio: RTL and testbench

- Parametrised Wishbone-classic GPIO peripheral for the SERV-based tops. Generalises the single write-only output latch into a banked register block:
  - width up to 32
  - per-pin direction
  - synchronised inputs
  - per-pin edge interrupts with W1C status
- Sits on the dbus behind the top-level address decode; drives pad-side out/oe and a level interrupt to i_timer_irq-style CPU inputs.

---
 rtl/tn_wb_gpio.sv | 195 +++++++++++++++++++
 tb/tb_tn_wb_gpio.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tn_wb_gpio.sv
// tn_wb_gpio: Wishbone-classic GPIO block with per-pin direction, synchronised
// inputs and per-pin edge interrupts with write-1-to-clear status.
//
// Optional feature macro: TN_GPIO_DEBOUNCE_EN adds a per-pin stable-count debouncer
// between the synchroniser and the edge detector / DATA_IN.
//
// Ports:
//   clk, resetn          clock, asynchronous active-low reset
//   i_wb_adr[4:0]        byte address; [4:2] selects one of eight word registers
//   i_wb_dat/i_wb_sel    write data and byte enables
//   i_wb_we, i_wb_cyc    write strobe, cycle/strobe
//   o_wb_rdt, o_wb_ack   read data (held until next read), single-cycle ack
//   i_gpio               asynchronous pad inputs
//   o_gpio, o_gpio_oe    pad output values (DATA_OUT) and enables (DIR)
//   o_irq                registered level interrupt, |(IRQ_STATUS & IRQ_EN)
//
// Register map (word index): 0 DATA_OUT, 1 DATA_IN, 2 DIR, 3 IRQ_EN,
// 4 IRQ_STATUS (w1c), 5 EDGE_RISE, 6 EDGE_FALL, 7 reserved (reads 0).
module tn_wb_gpio #(
    parameter int unsigned                GPIO_WIDTH      = 3,
    parameter logic [GPIO_WIDTH-1:0]      OUT_RESET       = '0,
    parameter logic [GPIO_WIDTH-1:0]      DIR_RESET       = '1,
    parameter int unsigned                DEBOUNCE_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [4:0]            i_wb_adr,
    input  logic [31:0]           i_wb_dat,
    input  logic [3:0]            i_wb_sel,
    input  logic                  i_wb_we,
    input  logic                  i_wb_cyc,
    output logic [31:0]           o_wb_rdt,
    output logic                  o_wb_ack,
    input  logic [GPIO_WIDTH-1:0] i_gpio,
    output logic [GPIO_WIDTH-1:0] o_gpio,
    output logic [GPIO_WIDTH-1:0] o_gpio_oe,
    output logic                  o_irq
);

    localparam int unsigned W = GPIO_WIDTH;

    logic          ack_q;
    logic          blk_q;
    logic [31:0]   rdt_q;
    logic          irq_q;
    logic [W-1:0]  out_q, out_d;
    logic [W-1:0]  dir_q, dir_d;
    logic [W-1:0]  en_q, en_d;
    logic [W-1:0]  sts_q, sts_d;
    logic [W-1:0]  rise_q, rise_d;
    logic [W-1:0]  fall_q, fall_d;
    logic [W-1:0]  sync1_q, sync_in_q;
    logic [W-1:0]  filt_in;
    logic [W-1:0]  prev_q;
    logic [W-1:0]  hit;

    logic          req, wr, rd;
    logic [2:0]    widx;
    logic [31:0]   bmask;
    logic [W-1:0]  wm, wd;
    logic [W-1:0]  rd_bits;
    logic [31:0]   rd_word;

    // blk_q suppresses any ack for a cycle that was in flight across reset: the master
    // must drop cyc once before a new request is accepted.
    assign req   = i_wb_cyc & ~ack_q & ~blk_q;
    assign wr    = req & i_wb_we;
    assign rd    = req & ~i_wb_we;
    assign widx  = i_wb_adr[4:2];
    assign bmask = {{8{i_wb_sel[3]}}, {8{i_wb_sel[2]}}, {8{i_wb_sel[1]}}, {8{i_wb_sel[0]}}};
    assign wm    = bmask[W-1:0];
    assign wd    = i_wb_dat[W-1:0];

    logic unused_bus;
    assign unused_bus = ^{i_wb_adr[1:0], i_wb_dat, bmask};

    // Input path: two-flop synchroniser, optional debouncer, previous-sample flop.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1_q   <= '0;
            sync_in_q <= '0;
            prev_q    <= '0;
        end else begin
            sync1_q   <= i_gpio;
            sync_in_q <= sync1_q;
            prev_q    <= filt_in;
        end
    end

`ifdef TN_GPIO_DEBOUNCE_EN
    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);

    logic [CntW-1:0] cnt_q [W];
    logic [W-1:0]    filt_q;

    // Counter runs only while the synchronised input disagrees with the filtered
    // value; any return to agreement restarts it, so short glitches never propagate.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            filt_q <= '0;
            for (int i = 0; i < int'(W); i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < int'(W); i++) begin
                if (sync_in_q[i] == filt_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == CntW'(DEBOUNCE_CYCLES - 1)) begin
                    filt_q[i] <= sync_in_q[i];
                    cnt_q[i]  <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign filt_in = filt_q;
`else
    logic unused_cfg;
    assign unused_cfg = ^DEBOUNCE_CYCLES;
    assign filt_in    = sync_in_q;
`endif

    assign hit = (filt_in & ~prev_q & rise_q) | (~filt_in & prev_q & fall_q);

    // Register next-state: byte-lane merge on write, W1C on status with set priority.
    always_comb begin
        out_d  = out_q;
        dir_d  = dir_q;
        en_d   = en_q;
        rise_d = rise_q;
        fall_d = fall_q;
        sts_d  = sts_q;
        if (wr) begin
            case (widx)
                3'd0:    out_d  = (out_q & ~wm) | (wd & wm);
                3'd2:    dir_d  = (dir_q & ~wm) | (wd & wm);
                3'd3:    en_d   = (en_q & ~wm) | (wd & wm);
                3'd4:    sts_d  = sts_q & ~(wd & wm);
                3'd5:    rise_d = (rise_q & ~wm) | (wd & wm);
                3'd6:    fall_d = (fall_q & ~wm) | (wd & wm);
                default: ;
            endcase
        end
        sts_d = sts_d | hit;
    end

    always_comb begin
        rd_bits = '0;
        case (widx)
            3'd0:    rd_bits = out_q;
            3'd1:    rd_bits = filt_in;
            3'd2:    rd_bits = dir_q;
            3'd3:    rd_bits = en_q;
            3'd4:    rd_bits = sts_q;
            3'd5:    rd_bits = rise_q;
            3'd6:    rd_bits = fall_q;
            default: rd_bits = '0;
        endcase
        rd_word          = '0;
        rd_word[W-1:0]   = rd_bits;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ack_q  <= 1'b0;
            blk_q  <= 1'b1;
            rdt_q  <= '0;
            irq_q  <= 1'b0;
            out_q  <= OUT_RESET;
            dir_q  <= DIR_RESET;
            en_q   <= '0;
            sts_q  <= '0;
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            ack_q  <= req;
            blk_q  <= blk_q & i_wb_cyc;
            if (rd) rdt_q <= rd_word;
            irq_q  <= |(sts_q & en_q);
            out_q  <= out_d;
            dir_q  <= dir_d;
            en_q   <= en_d;
            sts_q  <= sts_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign o_wb_ack  = ack_q;
    assign o_wb_rdt  = rdt_q;
    assign o_irq     = irq_q;
    assign o_gpio    = out_q;
    assign o_gpio_oe = dir_q;

endmodule

// File: tb/tb_tn_wb_gpio.sv
// Directed self-checking bench for tn_wb_gpio (GPIO_WIDTH=3, defaults otherwise).
module tb_tn_wb_gpio;

    logic        clk = 1'b0;
    logic        resetn;
    logic [4:0]  i_wb_adr;
    logic [31:0] i_wb_dat;
    logic [3:0]  i_wb_sel;
    logic        i_wb_we;
    logic        i_wb_cyc;
    logic [31:0] o_wb_rdt;
    logic        o_wb_ack;
    logic [2:0]  i_gpio;
    logic [2:0]  o_gpio;
    logic [2:0]  o_gpio_oe;
    logic        o_irq;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    tn_wb_gpio #(
        .GPIO_WIDTH      (3),
        .OUT_RESET       (3'b000),
        .DIR_RESET       (3'b111),
        .DEBOUNCE_CYCLES (16)
    ) u_dut (
        .clk       (clk),
        .resetn    (resetn),
        .i_wb_adr  (i_wb_adr),
        .i_wb_dat  (i_wb_dat),
        .i_wb_sel  (i_wb_sel),
        .i_wb_we   (i_wb_we),
        .i_wb_cyc  (i_wb_cyc),
        .o_wb_rdt  (o_wb_rdt),
        .o_wb_ack  (o_wb_ack),
        .i_gpio    (i_gpio),
        .o_gpio    (o_gpio),
        .o_gpio_oe (o_gpio_oe),
        .o_irq     (o_irq)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // All bus tasks start at posedge+1 and return at posedge+1 two edges later.
    task automatic wb_write(input string tag, input logic [4:0] adr, input logic [31:0] dat,
                            input logic [3:0] sel);
        i_wb_adr = adr;
        i_wb_dat = dat;
        i_wb_sel = sel;
        i_wb_we  = 1'b1;
        i_wb_cyc = 1'b1;
        @(posedge clk); #1;
        check_eq({tag, "_ack"}, 32'(o_wb_ack), 32'd1);
        i_wb_cyc = 1'b0;
        i_wb_we  = 1'b0;
        @(posedge clk); #1;
        check_eq({tag, "_ack_low"}, 32'(o_wb_ack), 32'd0);
    endtask

    task automatic wb_read(input string tag, input logic [4:0] adr, input logic [31:0] exp);
        i_wb_adr = adr;
        i_wb_sel = 4'hf;
        i_wb_we  = 1'b0;
        i_wb_cyc = 1'b1;
        @(posedge clk); #1;
        check_eq({tag, "_ack"}, 32'(o_wb_ack), 32'd1);
        check_eq(tag, o_wb_rdt, exp);
        i_wb_cyc = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] ack_pat;
        ack_pat  = 6'b101010;   // bit i = expected ack at sample i (LSB first: 0,1,0,1,0,1)
        resetn   = 1'b0;
        i_wb_adr = '0;
        i_wb_dat = '0;
        i_wb_sel = '0;
        i_wb_we  = 1'b0;
        i_wb_cyc = 1'b0;
        i_gpio   = 3'b000;
        #22;
        check_eq("rst_gpio", 32'(o_gpio), 32'd0);
        check_eq("rst_oe", 32'(o_gpio_oe), 32'd7);
        check_eq("rst_irq", 32'(o_irq), 32'd0);
        check_eq("rst_ack", 32'(o_wb_ack), 32'd0);
        check_eq("rst_rdt", o_wb_rdt, 32'd0);
        resetn = 1'b1;
        @(posedge clk); #1;

        wb_read("dir_rst", 5'h08, 32'h0000_0007);

        // Byte-lane writes to DATA_OUT.
        wb_write("dout_w", 5'h00, 32'hffff_ffff, 4'b0001);
        check_eq("dout_pins", 32'(o_gpio), 32'd7);
        wb_read("dout_rb", 5'h00, 32'h0000_0007);
        wb_write("dout_lane1", 5'h00, 32'h0000_0000, 4'b0010);
        check_eq("dout_lane1_pins", 32'(o_gpio), 32'd7);

        // cyc held high: ack every other cycle, reserved word reads 0.
        i_wb_adr = 5'h1c;
        i_wb_we  = 1'b0;
        i_wb_sel = 4'hf;
        i_wb_cyc = 1'b1;
        for (int i = 0; i < 6; i++) begin
            check_eq($sformatf("ack_pat%0d", i), 32'(o_wb_ack), 32'(ack_pat[i]));
            @(posedge clk); #1;
        end
        check_eq("rsvd_rd", o_wb_rdt, 32'd0);
        i_wb_cyc = 1'b0;
        @(posedge clk); #1;
        wb_write("rsvd_w", 5'h1c, 32'hffff_ffff, 4'hf);
        wb_read("rsvd_dout", 5'h00, 32'h0000_0007);
        wb_read("rsvd_dir", 5'h08, 32'h0000_0007);
        wb_read("rsvd_en", 5'h0c, 32'h0000_0000);
        wb_read("rsvd_rise", 5'h14, 32'h0000_0000);
        wb_read("rsvd_fall", 5'h18, 32'h0000_0000);

        wb_write("dir_w", 5'h08, 32'h0000_0005, 4'hf);
        check_eq("dir_oe", 32'(o_gpio_oe), 32'd5);

`ifndef TN_GPIO_DEBOUNCE_EN
        // Rising edge on pin 0 with interrupt enabled.
        wb_write("rise_w", 5'h14, 32'h1, 4'hf);
        wb_write("en_w", 5'h0c, 32'h1, 4'hf);
        i_gpio = 3'b001;
        @(posedge clk); #1;
        @(posedge clk); #1;
        i_wb_adr = 5'h10;
        i_wb_we  = 1'b0;
        i_wb_cyc = 1'b1;
        @(posedge clk); #1;          // status sets on this edge; read sees the old value
        check_eq("sts_pre_ack", 32'(o_wb_ack), 32'd1);
        check_eq("sts_pre", o_wb_rdt, 32'd0);
        check_eq("irq_pre", 32'(o_irq), 32'd0);
        i_wb_cyc = 1'b0;
        @(posedge clk); #1;
        check_eq("irq_set", 32'(o_irq), 32'd1);
        wb_read("sts_set", 5'h10, 32'h1);
        wb_read("din_out_pin", 5'h04, 32'h1);

        // W1C behaviour: zero and disabled lanes do nothing, enabled lane clears.
        wb_write("w1c_zero", 5'h10, 32'h0, 4'hf);
        wb_read("sts_after_zero", 5'h10, 32'h1);
        wb_write("w1c_lane", 5'h10, 32'h1, 4'b1110);
        wb_read("sts_after_lane", 5'h10, 32'h1);
        check_eq("irq_held", 32'(o_irq), 32'd1);
        wb_write("w1c_clr", 5'h10, 32'h1, 4'b0001);
        check_eq("irq_clr", 32'(o_irq), 32'd0);
        wb_read("sts_clr", 5'h10, 32'h0);

        // Both edges enabled: falling edge sets status, then a rise collides with W1C.
        wb_write("fall_w", 5'h18, 32'h1, 4'hf);
        i_gpio = 3'b000;
        repeat (4) @(posedge clk);
        #1;
        check_eq("irq_fall", 32'(o_irq), 32'd1);
        i_gpio = 3'b001;
        @(posedge clk); #1;
        @(posedge clk); #1;
        i_wb_adr = 5'h10;
        i_wb_dat = 32'h1;
        i_wb_sel = 4'b0001;
        i_wb_we  = 1'b1;
        i_wb_cyc = 1'b1;
        @(posedge clk); #1;          // W1C commit and new rise on the same edge
        check_eq("coll_ack", 32'(o_wb_ack), 32'd1);
        i_wb_cyc = 1'b0;
        i_wb_we  = 1'b0;
        @(posedge clk); #1;
        check_eq("coll_irq", 32'(o_irq), 32'd1);
        wb_read("coll_sts", 5'h10, 32'h1);
        wb_write("coll_clr", 5'h10, 32'h1, 4'hf);
        check_eq("coll_irq_clr", 32'(o_irq), 32'd0);

        // Disable path: pending status but IRQ_EN off keeps o_irq low.
        wb_write("en_off", 5'h0c, 32'h0, 4'hf);
        i_gpio = 3'b000;
        repeat (4) @(posedge clk);
        #1;
        check_eq("irq_disabled", 32'(o_irq), 32'd0);
        wb_read("sts_disabled", 5'h10, 32'h1);
`endif

        // Reset in the middle of a write: no commit, no late ack.
        i_wb_adr = 5'h00;
        i_wb_dat = 32'h5;
        i_wb_sel = 4'hf;
        i_wb_we  = 1'b1;
        i_wb_cyc = 1'b1;
        #2 resetn = 1'b0;
        #20;
        check_eq("mid_rst_ack", 32'(o_wb_ack), 32'd0);
        check_eq("mid_rst_oe", 32'(o_gpio_oe), 32'd7);
        resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_eq($sformatf("post_rst_ack%0d", i), 32'(o_wb_ack), 32'd0);
            check_eq($sformatf("post_rst_gpio%0d", i), 32'(o_gpio), 32'd0);
        end
        i_wb_cyc = 1'b0;
        i_wb_we  = 1'b0;
        @(posedge clk); #1;
        wb_read("post_rst_dir", 5'h08, 32'h0000_0007);
        wb_read("post_rst_sts", 5'h10, 32'h0000_0000);

`ifdef TN_GPIO_DEBOUNCE_EN
        // 10-cycle glitch is rejected; a held level appears 2+16 cycles after the change.
        wb_write("db_rise", 5'h14, 32'h2, 4'hf);
        i_gpio = 3'b010;
        repeat (10) @(posedge clk);
        #1;
        i_gpio = 3'b000;
        repeat (20) @(posedge clk);
        #1;
        wb_read("db_glitch_din", 5'h04, 32'h0);
        wb_read("db_glitch_sts", 5'h10, 32'h0);
        i_gpio = 3'b010;
        repeat (17) @(posedge clk);
        #1;
        wb_read("db_din_early", 5'h04, 32'h0);
        wb_read("db_din_late", 5'h04, 32'h2);
        wb_read("db_sts", 5'h10, 32'h2);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
